rgb_frame_source: RTL and testbench

Synthesizable raster pixel source that drives the `valid`/`iRed`/`iGreen`/`iBlue` stream consumed by the pixel-domain frame checker. It generates one or more frames of `IMG_WIDTH` x `IMG_HEIGHT` pixels on `pixclk`, with horizontal and vertical blanking, from a selectable test pattern. Benches and bring-up builds use it in place of the camera front end so the checker's frame-done, line-count and coordinate logic can be exercised deterministically.

---
 rtl/generic_pack.sv | 10 +
 rtl/rgb_frame_source_if.sv | 22 ++
 rtl/rgb_pattern_lut.sv | 36 +++
 rtl/rgb_frame_source.sv | 178 +++++++++++++++++
 tb/tb_rgb_frame_source.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/generic_pack.sv
// Shared types and default image geometry for the raster pixel source.
package generic_pack;

  localparam int img_width_bmp  = 64;
  localparam int img_height_bmp = 64;

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} src_state_t;
  typedef enum logic [1:0] {RAMP, BARS, CHECKER, FTAG} pattern_t;

endpackage

// File: rtl/rgb_frame_source_if.sv
// Pixel stream from the frame source to the pixel-domain frame checker.
interface rgb_frame_source_if #(
  parameter int CW = 12
);
  logic          valid;
  logic [7:0]    oRed;
  logic [7:0]    oGreen;
  logic [7:0]    oBlue;
  logic          sof;
  logic          eol;
  logic          eof;
  logic [CW-1:0] x_coord;
  logic [CW-1:0] y_coord;

  modport master (
    output valid, oRed, oGreen, oBlue, sof, eol, eof, x_coord, y_coord
  );

  modport slave (
    input valid, oRed, oGreen, oBlue, sof, eol, eof, x_coord, y_coord
  );
endinterface

// File: rtl/rgb_pattern_lut.sv
// Combinational test-pattern generator: (x, y, pattern, frame_idx) -> 24-bit RGB.
module rgb_pattern_lut import generic_pack::*; #(
  parameter int IMG_WIDTH = img_width_bmp,
  parameter int CW        = 12
) (
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  pattern_t      pattern,
  input  logic [7:0]    frame_idx,
  output logic [23:0]   rgb
);
  localparam int BAR_W = IMG_WIDTH / 8;

  logic [CW+7:0] xe;
  logic [CW+7:0] ye;
  logic [7:0]    x8;
  logic [7:0]    y8;
  logic [CW-1:0] bar;

  always_comb begin
    // Zero-extend so the low byte exists even for narrow coordinate widths.
    xe  = {8'd0, x};
    ye  = {8'd0, y};
    x8  = xe[7:0];
    y8  = ye[7:0];
    bar = x / CW'(BAR_W);
    rgb = '0;
    case (pattern)
      RAMP:    rgb = {x8, y8, 8'(x8 + y8)};
      BARS:    rgb = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
      CHECKER: rgb = {24{x8[3] ^ y8[3]}};
      FTAG:    rgb = {frame_idx, x8 ^ y8, ~x8};
      default: rgb = '0;
    endcase
  end
endmodule

// File: rtl/rgb_frame_source.sv
// Raster pixel source: frames of IMG_WIDTH x IMG_HEIGHT with H/V blanking and
// selectable test patterns, all outputs registered on pixclk.
module rgb_frame_source import generic_pack::*; #(
  parameter int IMG_WIDTH  = img_width_bmp,
  parameter int IMG_HEIGHT = img_height_bmp,
  parameter int HBLANK     = 8,
  parameter int VBLANK     = 2,
  parameter int CW         = 12
) (
  input  logic               pixclk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         pattern,
  input  logic [7:0]         num_frames,
  rgb_frame_source_if.master pix,
  output logic [7:0]         frame_idx,
  output logic               busy,
  output logic               done
);
  // The last line's horizontal blanking is folded into the vertical blanking
  // so the frame period is a whole number of line periods.
  localparam int VB_CYC = HBLANK + VBLANK * (IMG_WIDTH + HBLANK);
  localparam int BW     = $clog2(VB_CYC + 1) + 1;

  src_state_t    state_p0, state_p1;
  logic [CW-1:0] x_p0, x_p1;
  logic [CW-1:0] y_p0, y_p1;
  logic [BW-1:0] bcnt_p0, bcnt_p1;
  logic [7:0]    frame_p0, frame_p1;
  pattern_t      pat_p0, pat_p1;
  logic [7:0]    nfr_p0, nfr_p1;
  logic          stop_p0, stop_p1;
  logic          done_p0, done_p1;
  logic          frame_end, last_frame;
  logic          vld_p0, vld_p1;
  logic          sof_p0, sof_p1;
  logic          eol_p0, eol_p1;
  logic          eof_p0, eof_p1;
  logic          busy_p1;
  logic [23:0]   rgb_p0, rgb_p1;

  // p0: next-pixel decision (state, coordinates, frame bookkeeping)
  always_comb begin
    state_p0   = state_p1;
    x_p0       = x_p1;
    y_p0       = y_p1;
    bcnt_p0    = bcnt_p1;
    frame_p0   = frame_p1;
    pat_p0     = pat_p1;
    nfr_p0     = nfr_p1;
    done_p0    = 1'b0;
    frame_end  = 1'b0;
    // Live stop is included so a stop on the eof cycle still ends the run.
    last_frame = stop_p1 || stop ||
                 (nfr_p1 != 8'd0 && frame_p1 == nfr_p1 - 8'd1);
    case (state_p1)
      IDLE: begin
        if (start) begin
          state_p0 = ACTIVE;
          x_p0     = '0;
          y_p0     = '0;
          frame_p0 = '0;
          pat_p0   = pattern_t'(pattern);
          nfr_p0   = num_frames;
        end
      end
      ACTIVE: begin
        if (x_p1 == CW'(IMG_WIDTH - 1)) begin
          if (y_p1 != CW'(IMG_HEIGHT - 1)) begin
            state_p0 = generic_pack::HBLANK;
            bcnt_p0  = '0;
          end else if (VBLANK > 0) begin
            state_p0 = generic_pack::VBLANK;
            bcnt_p0  = '0;
          end else begin
            frame_end = 1'b1;
          end
        end else begin
          x_p0 = x_p1 + 1'b1;
        end
      end
      generic_pack::HBLANK: begin
        if (bcnt_p1 == BW'(HBLANK - 1)) begin
          state_p0 = ACTIVE;
          x_p0     = '0;
          y_p0     = y_p1 + 1'b1;
        end else begin
          bcnt_p0 = bcnt_p1 + 1'b1;
        end
      end
      generic_pack::VBLANK: begin
        if (bcnt_p1 == BW'(VB_CYC - 1)) frame_end = 1'b1;
        else                            bcnt_p0   = bcnt_p1 + 1'b1;
      end
      default: state_p0 = IDLE;
    endcase
    if (frame_end) begin
      if (last_frame) begin
        state_p0 = IDLE;
        done_p0  = 1'b1;
      end else begin
        state_p0 = ACTIVE;
        x_p0     = '0;
        y_p0     = '0;
        frame_p0 = frame_p1 + 8'd1;
        pat_p0   = pattern_t'(pattern);
      end
    end
    stop_p0 = (state_p0 != IDLE) && (stop_p1 || stop);
  end

  assign vld_p0 = (state_p0 == ACTIVE);
  assign sof_p0 = vld_p0 && x_p0 == '0 && y_p0 == '0;
  assign eol_p0 = vld_p0 && x_p0 == CW'(IMG_WIDTH - 1);
  assign eof_p0 = eol_p0 && y_p0 == CW'(IMG_HEIGHT - 1);

  rgb_pattern_lut #(
    .IMG_WIDTH (IMG_WIDTH),
    .CW        (CW)
  ) u_lut (
    .x         (x_p0),
    .y         (y_p0),
    .pattern   (pat_p0),
    .frame_idx (frame_p0),
    .rgb       (rgb_p0)
  );

  // p1: registered state and outputs
  always_ff @(posedge pixclk) begin
    if (!reset) begin
      state_p1 <= IDLE;
      x_p1     <= '0;
      y_p1     <= '0;
      bcnt_p1  <= '0;
      frame_p1 <= '0;
      pat_p1   <= RAMP;
      nfr_p1   <= '0;
      stop_p1  <= 1'b0;
      done_p1  <= 1'b0;
      busy_p1  <= 1'b0;
      vld_p1   <= 1'b0;
      sof_p1   <= 1'b0;
      eol_p1   <= 1'b0;
      eof_p1   <= 1'b0;
      rgb_p1   <= '0;
    end else begin
      state_p1 <= state_p0;
      x_p1     <= x_p0;
      y_p1     <= y_p0;
      bcnt_p1  <= bcnt_p0;
      frame_p1 <= frame_p0;
      pat_p1   <= pat_p0;
      nfr_p1   <= nfr_p0;
      stop_p1  <= stop_p0;
      done_p1  <= done_p0;
      busy_p1  <= (state_p0 != IDLE);
      vld_p1   <= vld_p0;
      sof_p1   <= sof_p0;
      eol_p1   <= eol_p0;
      eof_p1   <= eof_p0;
      rgb_p1   <= vld_p0 ? rgb_p0 : 24'd0;
    end
  end

  assign pix.valid   = vld_p1;
  assign pix.oRed    = rgb_p1[23:16];
  assign pix.oGreen  = rgb_p1[15:8];
  assign pix.oBlue   = rgb_p1[7:0];
  assign pix.sof     = sof_p1;
  assign pix.eol     = eol_p1;
  assign pix.eof     = eof_p1;
  assign pix.x_coord = x_p1;
  assign pix.y_coord = y_p1;
  assign frame_idx   = frame_p1;
  assign busy        = busy_p1;
  assign done        = done_p1;
endmodule

// File: tb/tb_rgb_frame_source.sv
// Directed bench for rgb_frame_source: 64x64 frames, one DUT with HBLANK 8 /
// VBLANK 2 and one with HBLANK 1 / VBLANK 0.
module tb_rgb_frame_source;
  localparam int CW = 12;

  logic pixclk = 1'b0;
  always #5 pixclk = ~pixclk;

  int cyc = 0;
  always @(posedge pixclk) cyc <= cyc + 1;

  logic       reset;
  logic       start_c, stop_c, sel;
  logic [1:0] pat_c;
  logic [7:0] nf_c;
  logic       start0, stop0, start1, stop1;
  logic [7:0] fi0, fi1;
  logic       busy0, busy1, done0, done1;

  assign start0 = start_c & ~sel;
  assign stop0  = stop_c  & ~sel;
  assign start1 = start_c &  sel;
  assign stop1  = stop_c  &  sel;

  rgb_frame_source_if #(.CW(CW)) pix0 ();
  rgb_frame_source_if #(.CW(CW)) pix1 ();

  rgb_frame_source #(.IMG_WIDTH(64), .IMG_HEIGHT(64), .HBLANK(8), .VBLANK(2), .CW(CW)) dut0 (
    .pixclk(pixclk), .reset(reset), .start(start0), .stop(stop0), .pattern(pat_c),
    .num_frames(nf_c), .pix(pix0), .frame_idx(fi0), .busy(busy0), .done(done0));

  rgb_frame_source #(.IMG_WIDTH(64), .IMG_HEIGHT(64), .HBLANK(1), .VBLANK(0), .CW(CW)) dut1 (
    .pixclk(pixclk), .reset(reset), .start(start1), .stop(stop1), .pattern(pat_c),
    .num_frames(nf_c), .pix(pix1), .frame_idx(fi1), .busy(busy1), .done(done1));

  logic          m_valid, m_sof, m_eol, m_eof, m_busy, m_done;
  logic [23:0]   m_rgb;
  logic [CW-1:0] m_x, m_y;
  logic [7:0]    m_fi;

  always_comb begin
    m_valid = pix0.valid; m_sof = pix0.sof; m_eol = pix0.eol; m_eof = pix0.eof;
    m_rgb = {pix0.oRed, pix0.oGreen, pix0.oBlue};
    m_x = pix0.x_coord; m_y = pix0.y_coord; m_fi = fi0; m_busy = busy0; m_done = done0;
    if (sel) begin
      m_valid = pix1.valid; m_sof = pix1.sof; m_eol = pix1.eol; m_eof = pix1.eof;
      m_rgb = {pix1.oRed, pix1.oGreen, pix1.oBlue};
      m_x = pix1.x_coord; m_y = pix1.y_coord; m_fi = fi1; m_busy = busy1; m_done = done1;
    end
  end

  int          n_cmp = 0, n_err = 0;
  int          t0, n_vld, n_sof, n_eol, n_eof, n_done, n_cz, done_rel;
  logic        busy_at_done, seen_done;
  int          sof_rel[$], eof_rel[$];
  logic [7:0]  sof_red[$], sof_fi[$];
  logic [23:0] pix_mem[64][64];
  logic [23:0] eof_xy;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int qi(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  function automatic logic [7:0] qb(input logic [7:0] q[$], input int i);
    return (q.size() > i) ? q[i] : 8'hEE;
  endfunction

  // Launch a run on the selected DUT and watch it until done (plus a tail).
  // smode 1: pulse stop at (0,10) of frame sframe; smode 2: stop on its eof.
  task automatic run(input logic s, input logic [1:0] p, input logic [7:0] nf, input logic stp,
                     input int max_rel, input int tail, input int smode, input int sframe,
                     input int bstart_rel);
    int rel;
    int after;
    n_vld = 0; n_sof = 0; n_eol = 0; n_eof = 0; n_done = 0; n_cz = 0; done_rel = -1;
    busy_at_done = 1'b1; seen_done = 1'b0; eof_xy = '0; after = 0;
    sof_rel.delete(); eof_rel.delete(); sof_red.delete(); sof_fi.delete();
    sel = s; pat_c = p; nf_c = nf; start_c = 1'b1; stop_c = stp; t0 = cyc;
    @(negedge pixclk);
    forever begin
      rel = cyc - t0;
      start_c = (rel == bstart_rel);
      if (rel == bstart_rel) nf_c = 8'd1;
      stop_c = 1'b0;
      if (m_valid) begin
        n_vld++;
        pix_mem[m_y[5:0]][m_x[5:0]] = m_rgb;
      end else if (m_rgb != 24'd0) begin
        n_cz++;
      end
      if (m_sof) begin
        n_sof++; sof_rel.push_back(rel); sof_red.push_back(m_rgb[23:16]); sof_fi.push_back(m_fi);
      end
      if (m_eol) n_eol++;
      if (m_eof) begin
        n_eof++; eof_rel.push_back(rel); eof_xy = {m_y, m_x};
      end
      if (smode == 1 && m_valid && int'(m_fi) == sframe && int'(m_y) == 10 && int'(m_x) == 0)
        stop_c = 1'b1;
      if (smode == 2 && m_eof && int'(m_fi) == sframe) stop_c = 1'b1;
      if (m_done) begin
        n_done++;
        if (!seen_done) begin done_rel = rel; busy_at_done = m_busy; end
        seen_done = 1'b1;
      end
      if (seen_done) begin
        if (after >= tail) break;
        after++;
      end else if (rel >= max_rel) begin
        break;
      end
      @(negedge pixclk);
    end
    start_c = 1'b0; stop_c = 1'b0;
    check_val("done_seen", 32'(seen_done), 32'd1);
  endtask

  initial begin
    int found_rel, lines_ok, rel;
    logic any_done, line_ok;
    reset = 1'b0; start_c = 1'b0; stop_c = 1'b0; sel = 1'b0; pat_c = 2'd0; nf_c = 8'd0;
    repeat (3) @(negedge pixclk);
    check_val("rst_valid", 32'(pix0.valid), 32'd0);
    check_val("rst_busy",  32'(busy0), 32'd0);
    check_val("rst_done",  32'(done0), 32'd0);
    check_val("rst_fi",    32'(fi0), 32'd0);
    check_val("rst_xy",    32'({pix0.y_coord, pix0.x_coord}), 32'd0);
    check_val("rst_rgb",   32'({pix0.oRed, pix0.oGreen, pix0.oBlue}), 32'd0);
    reset = 1'b1;
    @(negedge pixclk);

    // Ramp, single frame
    run(1'b0, 2'd0, 8'd1, 1'b0, 6000, 0, 0, 0, -1);
    check_val("ramp_nvalid",  n_vld, 4096);
    check_val("ramp_first",   qi(sof_rel, 0), 1);
    check_val("ramp_px5_3",   pix_mem[3][5], 32'h050308);
    check_val("ramp_px63_63", pix_mem[63][63], 32'h3F3F7E);
    check_val("ramp_done_at", done_rel, 1 + 66 * 72);
    check_val("ramp_busy_dn", 32'(busy_at_done), 32'd0);
    check_val("ramp_nsof",    n_sof, 1);
    check_val("ramp_neol",    n_eol, 64);
    check_val("ramp_neof",    n_eof, 1);
    check_val("ramp_blank0",  n_cz, 0);

    // Colour bars
    run(1'b0, 2'd1, 8'd1, 1'b0, 6000, 0, 0, 0, -1);
    check_val("bars_x0",  pix_mem[0][0],   32'h000000);
    check_val("bars_x7",  pix_mem[20][7],  32'h000000);
    check_val("bars_x8",  pix_mem[0][8],   32'h0000FF);
    check_val("bars_x16", pix_mem[1][16],  32'h00FF00);
    check_val("bars_x32", pix_mem[2][32],  32'hFF0000);
    check_val("bars_x56", pix_mem[63][56], 32'hFFFFFF);
    lines_ok = 0;
    for (int y = 0; y < 64; y++) begin
      line_ok = 1'b1;
      for (int x = 0; x < 8; x++) begin
        if (pix_mem[y][x] != 24'h000000) line_ok = 1'b0;
        if (pix_mem[y][56 + x] != 24'hFFFFFF) line_ok = 1'b0;
      end
      if (pix_mem[y][8] != 24'h0000FF) line_ok = 1'b0;
      if (line_ok) lines_ok++;
    end
    check_val("bars_lines", lines_ok, 64);

    // start and stop together in IDLE: exactly one frame (checker pattern)
    run(1'b0, 2'd2, 8'd0, 1'b1, 6000, 200, 0, 0, -1);
    check_val("ss_nsof",    n_sof, 1);
    check_val("ss_done_at", done_rel, 4753);
    check_val("chk_px0_0",  pix_mem[0][0], 32'h000000);
    check_val("chk_px8_0",  pix_mem[0][8], 32'hFFFFFF);
    check_val("chk_px8_8",  pix_mem[8][8], 32'h000000);

    // Multi-frame, frame-tagged
    run(1'b0, 2'd3, 8'd3, 1'b0, 16000, 100, 0, 0, -1);
    check_val("mf_sof0",   qi(sof_rel, 0), 1);
    check_val("mf_sof1",   qi(sof_rel, 1), 4753);
    check_val("mf_sof2",   qi(sof_rel, 2), 9505);
    check_val("mf_red0",   qb(sof_red, 0), 0);
    check_val("mf_red1",   qb(sof_red, 1), 1);
    check_val("mf_red2",   qb(sof_red, 2), 2);
    check_val("mf_fi2",    qb(sof_fi, 2), 2);
    check_val("mf_px5_3",  pix_mem[3][5], 32'h0206FA);
    check_val("mf_ndone",  n_done, 1);
    check_val("mf_doneat", done_rel, 1 + 3 * 4752);

    // Continuous, stop mid frame 2, start during busy ignored
    run(1'b0, 2'd0, 8'd0, 1'b0, 20000, 3000, 1, 2, 100);
    check_val("ct_nsof",   n_sof, 3);
    check_val("ct_neof",   n_eof, 3);
    check_val("ct_ndone",  n_done, 1);
    check_val("ct_doneat", done_rel, 1 + 3 * 4752);

    // Reset mid-line at x=20, y=10
    sel = 1'b0; pat_c = 2'd0; nf_c = 8'd0; start_c = 1'b1; t0 = cyc;
    @(negedge pixclk);
    start_c = 1'b0;
    found_rel = -1;
    for (int i = 0; i < 2000; i++) begin
      rel = cyc - t0;
      if (pix0.valid && int'(pix0.x_coord) == 20 && int'(pix0.y_coord) == 10) begin
        found_rel = rel;
        break;
      end
      @(negedge pixclk);
    end
    check_val("rst_reach", found_rel, 1 + 10 * 72 + 20);
    reset = 1'b0;
    @(negedge pixclk);
    check_val("mrst_valid", 32'(pix0.valid), 32'd0);
    check_val("mrst_busy",  32'(busy0), 32'd0);
    check_val("mrst_done",  32'(done0), 32'd0);
    check_val("mrst_xy",    32'({pix0.y_coord, pix0.x_coord}), 32'd0);
    check_val("mrst_rgb",   32'({pix0.oRed, pix0.oGreen, pix0.oBlue}), 32'd0);
    check_val("mrst_flags", 32'({pix0.sof, pix0.eol, pix0.eof}), 32'd0);
    reset = 1'b1;
    any_done = 1'b0;
    repeat (5) begin
      @(negedge pixclk);
      any_done = any_done | done0;
    end
    check_val("mrst_nodone", 32'(any_done), 32'd0);
    check_val("mrst_idle",   32'(busy0), 32'd0);
    start_c = 1'b1;
    @(negedge pixclk);
    start_c = 1'b0;
    check_val("rs_valid", 32'(pix0.valid), 32'd1);
    check_val("rs_sof",   32'(pix0.sof), 32'd1);
    check_val("rs_xy",    32'({pix0.y_coord, pix0.x_coord}), 32'd0);
    check_val("rs_fi",    32'(fi0), 32'd0);
    reset = 1'b0;
    @(negedge pixclk);
    reset = 1'b1;
    @(negedge pixclk);

    // VBLANK=0, HBLANK=1: back-to-back frames
    run(1'b1, 2'd3, 8'd2, 1'b0, 9000, 50, 0, 0, -1);
    check_val("vb0_eof0",   qi(eof_rel, 0), 4159);
    check_val("vb0_sof1",   qi(sof_rel, 1), 4160);
    check_val("vb0_red1",   qb(sof_red, 1), 1);
    check_val("vb0_fi1",    qb(sof_fi, 1), 1);
    check_val("vb0_eofxy",  eof_xy, 32'h03F03F);
    check_val("vb0_doneat", done_rel, 8319);
    check_val("vb0_busydn", 32'(busy_at_done), 32'd0);

    // Stop asserted on the eof cycle ends the run after that frame
    run(1'b1, 2'd0, 8'd0, 1'b0, 5000, 300, 2, 0, -1);
    check_val("se_nsof",   n_sof, 1);
    check_val("se_neof",   n_eof, 1);
    check_val("se_ndone",  n_done, 1);
    check_val("se_doneat", done_rel, 4160);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
